// File: rtl/ram_port_arbiter.sv
// Two-master front end for a 1W/1R RAM with independent round-robin
// write/read arbitration and a zero-fill init sweep.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    input  logic                  init_start,
    output logic                  busy,
    output logic                  init_done,
    output logic                  ram_wr_enb,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_enb,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        INIT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic          init_last;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          idle;
    logic          in_init;
    logic          wc0, wc1, rc0, rc1;
    logic          wg0, wg1, rg0, rg1;

    // Grants and RAM enables are gated by rst so nothing leaks during reset.
    assign idle    = (state == IDLE) && !rst;
    assign in_init = (state == INIT) && !rst;

    assign wc0 = m0_req && m0_we;
    assign wc1 = m1_req && m1_we;
    assign rc0 = m0_req && !m0_we;
    assign rc1 = m1_req && !m1_we;

    // Pointer 0 favours m0, 1 favours m1.
    assign wg0 = idle && wc0 && (!wc1 || !wr_ptr);
    assign wg1 = idle && wc1 && (!wc0 || wr_ptr);
    assign rg0 = idle && rc0 && (!rc1 || !rd_ptr);
    assign rg1 = idle && rc1 && (!rc0 || rd_ptr);

    assign m0_gnt   = wg0 || rg0;
    assign m1_gnt   = wg1 || rg1;
    assign m0_rdata = ram_rd_data;
    assign m1_rdata = ram_rd_data;
    assign busy     = (state == INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        init_last = 1'b0;
        unique case (state)
            IDLE: begin
                if (init_start) begin
                    state_nxt = INIT;
                end
            end
            INIT: begin
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    init_last = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            init_done <= 1'b0;
        end else begin
            if (state == INIT && !init_last) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
            if (wg0) wr_ptr <= 1'b1;
            if (wg1) wr_ptr <= 1'b0;
            if (rg0) rd_ptr <= 1'b1;
            if (rg1) rd_ptr <= 1'b0;
            m0_rvalid <= rg0;
            m1_rvalid <= rg1;
            init_done <= init_last;
        end
    end

    always_comb begin
        ram_wr_enb  = 1'b0;
        ram_wr_addr = '0;
        ram_wr_data = '0;
        unique case (1'b1)
            in_init: begin
                ram_wr_enb  = 1'b1;
                ram_wr_addr = ADDR_WIDTH'(cnt);
            end
            wg0: begin
                ram_wr_enb  = 1'b1;
                ram_wr_addr = m0_addr;
                ram_wr_data = m0_wdata;
            end
            wg1: begin
                ram_wr_enb  = 1'b1;
                ram_wr_addr = m1_addr;
                ram_wr_data = m1_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        ram_rd_enb  = 1'b0;
        ram_rd_addr = '0;
        unique case (1'b1)
            rg0: begin
                ram_rd_enb  = 1'b1;
                ram_rd_addr = m0_addr;
            end
            rg1: begin
                ram_rd_enb  = 1'b1;
                ram_rd_addr = m1_addr;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Scoreboard bench for ram_port_arbiter with a behavioural
// read-before-write RAM attached to its command ports.
module tb_ram_port_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic          m0_gnt, m0_rvalid;
    logic [DW-1:0] m0_rdata;
    logic          m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m1_gnt, m1_rvalid;
    logic [DW-1:0] m1_rdata;
    logic          init_start = 1'b0;
    logic          busy, init_done;
    logic          ram_wr_enb, ram_rd_enb;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_rd_data = '0;

    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    ram_port_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m0_req(m0_req),
        .m0_we(m0_we),
        .m0_addr(m0_addr),
        .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req),
        .m1_we(m1_we),
        .m1_addr(m1_addr),
        .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .init_start(init_start),
        .busy(busy),
        .init_done(init_done),
        .ram_wr_enb(ram_wr_enb),
        .ram_wr_addr(ram_wr_addr),
        .ram_wr_data(ram_wr_data),
        .ram_rd_enb(ram_rd_enb),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Nonblocking read and write give read-before-write on a shared address.
    always @(posedge clk) begin
        if (ram_wr_enb) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_rd_enb) ram_rd_data <= mem[ram_rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = a; m0_wdata = d;
        @(negedge clk);
        chk("wr0_gnt", m0_gnt, 1);
    endtask

    task automatic rd0(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = a;
        @(negedge clk);
        chk("rd0_gnt", m0_gnt, 1);
        q0.push_back('{cyc + 1, d});
    endtask

    // Monitor: every rvalid must match the oldest pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (m0_rvalid) begin
            if (q0.size() == 0) chk("m0_rvalid_unexpected", 1, 0);
            else begin
                e = q0.pop_front();
                chk("m0_rdata", m0_rdata, e.data);
                chk("m0_rvalid_cycle", cyc, e.due);
            end
        end else if (q0.size() > 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            chk("m0_rvalid_missing", m0_rvalid, 1);
        end
        if (m1_rvalid) begin
            if (q1.size() == 0) chk("m1_rvalid_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                chk("m1_rdata", m1_rdata, e.data);
                chk("m1_rvalid_cycle", cyc, e.due);
            end
        end else if (q1.size() > 0 && q1[0].due <= cyc) begin
            e = q1.pop_front();
            chk("m1_rvalid_missing", m1_rvalid, 1);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state with requests already pending
        m0_req = 1'b1; m0_we = 1'b1; m1_req = 1'b1; m1_we = 1'b0;
        @(negedge clk);
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_wr_enb", ram_wr_enb, 0);
        chk("rst_rd_enb", ram_rd_enb, 0);
        chk("rst_busy", busy, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_m0_rvalid", m0_rvalid, 0);
        chk("rst_m1_rvalid", m1_rvalid, 0);

        // Write conflict
        tick();
        rst = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd5; m0_wdata = 8'hAA;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 6'd9; m1_wdata = 8'h55;
        @(negedge clk);
        chk("wc1_m0_gnt", m0_gnt, 1);
        chk("wc1_m1_gnt", m1_gnt, 0);
        chk("wc1_wr_addr", ram_wr_addr, 5);
        chk("wc1_wr_data", ram_wr_data, 8'hAA);
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("wc2_m1_gnt", m1_gnt, 1);
        chk("wc2_wr_addr", ram_wr_addr, 9);
        chk("wc2_wr_data", ram_wr_data, 8'h55);

        // Read both back, simultaneous requests
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd5;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd9;
        @(negedge clk);
        chk("rb1_m0_gnt", m0_gnt, 1);
        chk("rb1_m1_gnt", m1_gnt, 0);
        chk("rb1_rd_addr", ram_rd_addr, 5);
        q0.push_back('{cyc + 1, 8'hAA});
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("rb2_m1_gnt", m1_gnt, 1);
        q1.push_back('{cyc + 1, 8'h55});
        tick();
        m1_req = 1'b0;

        // Read contention: held requests alternate
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd5;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd9;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            @(negedge clk);
            chk("cont_m0_gnt", m0_gnt, (i % 2) == 0);
            chk("cont_m1_gnt", m1_gnt, (i % 2) == 1);
            if ((i % 2) == 0) q0.push_back('{cyc + 1, 8'hAA});
            else q1.push_back('{cyc + 1, 8'h55});
        end
        tick();
        m0_req = 1'b0; m1_req = 1'b0;

        // Same-address write and read in one cycle
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd3; m0_wdata = 8'h11;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd3;
        @(negedge clk);
        chk("haz_m0_gnt", m0_gnt, 1);
        chk("haz_m1_gnt", m1_gnt, 1);
        q1.push_back('{cyc + 1, 8'h00});
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        chk("haz2_m1_gnt", m1_gnt, 1);
        q1.push_back('{cyc + 1, 8'h11});
        tick();
        m1_req = 1'b0;

        // Fill, then init with a read granted in the start cycle
        for (int a = 0; a < DEPTH; a++) wr0(AW'(a), 8'hFF);
        tick();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 6'd5; init_start = 1'b1;
        @(negedge clk);
        chk("istart_m0_gnt", m0_gnt, 1);
        chk("istart_busy", busy, 0);
        q0.push_back('{cyc + 1, 8'hFF});
        tick();
        init_start = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 6'd40; m0_wdata = 8'h77;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 6'd7;
        for (int s = 0; s < DEPTH; s++) begin
            if (s > 0) tick();
            init_start = (s == 10);
            @(negedge clk);
            chk("sweep_busy_wren", {busy, ram_wr_enb}, 2'b11);
            chk("sweep_wr_addr", ram_wr_addr, s);
            chk("sweep_wr_data", ram_wr_data, 0);
            chk("sweep_quiet",
                {m0_gnt, m1_gnt, ram_rd_enb, init_done}, 4'b0000);
        end
        tick();
        init_start = 1'b0;
        @(negedge clk);
        chk("idone_pulse", init_done, 1);
        chk("idone_busy", busy, 0);
        chk("idone_m0_gnt", m0_gnt, 1);
        chk("idone_m1_gnt", m1_gnt, 1);
        chk("idone_wr_addr", ram_wr_addr, 40);
        q1.push_back('{cyc + 1, 8'h00});
        tick();
        m0_req = 1'b0; m1_req = 1'b0;
        @(negedge clk);
        chk("idone_single", init_done, 0);
        rd0(6'd0, 8'h00);
        rd0(6'd30, 8'h00);
        rd0(6'd63, 8'h00);
        rd0(6'd40, 8'h77);
        tick();
        m0_req = 1'b0;

        // Reset in the middle of a sweep
        for (int a = 0; a < DEPTH; a++) wr0(AW'(a), 8'hFF);
        tick();
        m0_req = 1'b0;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        repeat (20) tick();
        chk("mid_busy", busy, 1);
        chk("mid_wr_addr", ram_wr_addr, 20);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_enb", ram_wr_enb, 0);
        chk("mid_rst_init_done", init_done, 0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {busy, init_done, ram_wr_enb}, 3'b000);
            tick();
        end
        rd0(6'd30, 8'hFF);
        rd0(6'd10, 8'h00);
        rd0(6'd19, 8'h00);
        rd0(6'd20, 8'hFF);
        tick();
        m0_req = 1'b0;

        for (int k = 0; k < 10 && (q0.size() + q1.size()) > 0; k++)
            @(posedge clk);
        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
